multi_debounce: RTL and testbench

Parametrised, multi-channel successor to the single-bit in→out lab block. Each channel synchronises an asynchronous input (switch or button) into the clk domain, filters glitches with a stability counter, and presents a clean level plus one-cycle rise and fall pulses. It sits between board-level inputs and the lab datapath or FSM logic.

---
 rtl/multi_debounce_pkg.sv | 26 ++
 rtl/multi_debounce_channel.sv | 75 +++++++
 rtl/multi_debounce.sv | 46 ++++
 tb/tb_multi_debounce.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// The default parameter values are kept here so the top level and the per-channel block use the same defaults.
package multi_debounce_pkg;

  localparam int DEF_CHANNELS        = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // The stability counter always needs at least one bit, even when DEBOUNCE_CYCLES is 1.
  function automatic int cnt_width(input int cycles);
    return (clog2(cycles) < 1) ? 1 : clog2(cycles);
  endfunction

endpackage

// File: rtl/multi_debounce_channel.sv
// Single-bit debouncer: a synchroniser chain, a stability counter, and registered level/edge outputs.
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL_BIT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic change_nxt
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   out_d;
  logic                   rise_d;
  logic                   fall_d;

  assign s = sync_p0[SYNC_STAGES-1];

  // stage p0: synchroniser chain, din enters at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= {SYNC_STAGES{RESET_VAL_BIT}};
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
    end
  end

  // The counter only advances while s disagrees with out.
  // Any agreement clears it, so partial counts are never carried over.
  always_comb begin
    cnt_d  = '0;
    out_d  = dout;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s != dout) begin
      if (cnt_q == CNT_LAST) begin
        out_d  = s;
        rise_d = s;
        fall_d = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign change_nxt = rise_d | fall_d;

  // stage p1: debounced level, counter and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= RESET_VAL_BIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      dout  <= out_d;
      rise  <= rise_d;
      fall  <= fall_d;
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: independent per-channel filters plus a shared change flag.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int                  CHANNELS        = DEF_CHANNELS,
  parameter int                  SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  logic [CHANNELS-1:0] chg;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL_BIT  (RESET_VAL[i])
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (in[i]),
      .dout      (out[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .change_nxt(chg[i])
    );
  end

  // stage p1: registered from the channels' next-cycle pulses so it aligns with rise/fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_change <= 1'b0;
    end else begin
      any_change <= |chg;
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: three builds (default, all-ones reset value, one-cycle debounce) checked against a behavioural model.
module tb_multi_debounce;
  import multi_debounce_pkg::*;

  localparam int SYNC = DEF_SYNC_STAGES;
  localparam logic [3:0] RV [3] = '{4'h0, 4'hF, 4'h0};
  localparam int         DC [3] = '{DEF_DEBOUNCE_CYCLES, DEF_DEBOUNCE_CYCLES, 1};

  logic       clk;
  logic       rst_n;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] in_c;
  logic [3:0] d_out  [3];
  logic [3:0] d_rise [3];
  logic [3:0] d_fall [3];
  logic       d_any  [3];

  int n_cmp = 0;
  int n_err = 0;

  assign in_b = ~in_a;
  assign in_c = in_a;

  multi_debounce u0 (
    .clk(clk), .rst_n(rst_n), .in(in_a),
    .out(d_out[0]), .rise(d_rise[0]), .fall(d_fall[0]), .any_change(d_any[0])
  );

  multi_debounce #(.RESET_VAL(4'hF)) u1 (
    .clk(clk), .rst_n(rst_n), .in(in_b),
    .out(d_out[1]), .rise(d_rise[1]), .fall(d_fall[1]), .any_change(d_any[1])
  );

  multi_debounce #(.DEBOUNCE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in(in_c),
    .out(d_out[2]), .rise(d_rise[2]), .fall(d_fall[2]), .any_change(d_any[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] cur_in(input int i);
    case (i)
      0:       return in_a;
      1:       return in_b;
      default: return in_c;
    endcase
  endfunction

  // Behavioural model: the filter sees the input SYNC edges late; a channel's level flips once
  // that delayed value has disagreed with it on DC consecutive edges, producing a one-cycle pulse.
  logic [3:0] m_out  [3];
  logic [3:0] m_rise [3];
  logic [3:0] m_fall [3];
  logic       m_any  [3];
  logic [3:0] m_hist [3][SYNC];
  int         m_run  [3][4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_out[i]  = RV[i];
        m_rise[i] = 4'h0;
        m_fall[i] = 4'h0;
        m_any[i]  = 1'b0;
        for (int k = 0; k < SYNC; k++) m_hist[i][k] = RV[i];
        for (int c = 0; c < 4; c++) m_run[i][c] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        logic [3:0] seen;
        seen = m_hist[i][SYNC-1];
        for (int k = SYNC - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = cur_in(i);
        m_rise[i] = 4'h0;
        m_fall[i] = 4'h0;
        for (int c = 0; c < 4; c++) begin
          if (seen[c] != m_out[i][c]) begin
            m_run[i][c] = m_run[i][c] + 1;
            if (m_run[i][c] >= DC[i]) begin
              m_out[i][c] = seen[c];
              if (seen[c]) m_rise[i][c] = 1'b1;
              else         m_fall[i][c] = 1'b1;
              m_run[i][c] = 0;
            end
          end else begin
            m_run[i][c] = 0;
          end
        end
        m_any[i] = |(m_rise[i] | m_fall[i]);
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.out", i),        d_out[i],          m_out[i]);
      check($sformatf("u%0d.rise", i),       d_rise[i],         m_rise[i]);
      check($sformatf("u%0d.fall", i),       d_fall[i],         m_fall[i]);
      check($sformatf("u%0d.any_change", i), {3'b000, d_any[i]}, {3'b000, m_any[i]});
    end
  end

  logic cnt_en = 1'b0;
  int   rise2_cnt = 0;
  int   fall2_cnt = 0;
  always @(negedge clk) begin
    if (cnt_en && d_rise[0][2]) rise2_cnt++;
    if (cnt_en && d_fall[0][2]) fall2_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_a  = 4'h0;
    step(3);
    rst_n = 1'b1;
    step(3);

    // single channel rise: out[0] changes on edge 18
    in_a = 4'b0001;
    step(17);
    check("t1.out_edge17", d_out[0], 4'b0000);
    step(1);
    check("t1.out_edge18",  d_out[0],  4'b0001);
    check("t1.rise_edge18", d_rise[0], 4'b0001);
    check("t1.any_edge18",  {3'b000, d_any[0]}, 4'b0001);
    step(1);
    check("t1.rise_edge19", d_rise[0], 4'b0000);
    check("t1.any_edge19",  {3'b000, d_any[0]}, 4'b0000);
    in_a = 4'b0000;
    step(25);

    // 15-cycle pulse is rejected, 16-cycle pulse is accepted
    in_a[1] = 1'b1;
    step(15);
    in_a[1] = 1'b0;
    step(30);
    check("t2.short_out", d_out[0], 4'b0000);
    in_a[1] = 1'b1;
    step(16);
    in_a[1] = 1'b0;
    step(40);

    // bounce on channel 2 then a steady high
    cnt_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (k % 3 == 0) in_a[2] = ~in_a[2];
      step(1);
    end
    in_a[2] = 1'b1;
    step(17);
    check("t3.out_edge17", d_out[0], 4'b0000);
    step(1);
    check("t3.out_edge18", d_out[0], 4'b0100);
    step(10);
    cnt_en = 1'b0;
    check("t3.rise2_count", 4'(rise2_cnt), 4'd1);
    check("t3.fall2_count", 4'(fall2_cnt), 4'd0);
    in_a = 4'b0000;
    step(25);

    // all channels change together
    in_a = 4'b1111;
    step(18);
    check("t4.out",  d_out[0],  4'b1111);
    check("t4.rise", d_rise[0], 4'b1111);
    check("t4.any",  {3'b000, d_any[0]}, 4'b0001);
    step(1);
    check("t4.any_next", {3'b000, d_any[0]}, 4'b0000);
    in_a = 4'b0000;
    step(25);

    // asynchronous reset in mid-count discards progress
    in_a = 4'b0100;
    step(25);
    in_a = 4'b1100;
    step(10);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.u0_out_async", d_out[0], 4'b0000);
    check("t5.u1_out_async", d_out[1], 4'b1111);
    check("t5.u2_out_async", d_out[2], 4'b0000);
    step(2);
    rst_n = 1'b1;
    step(17);
    check("t5.out_edge17", d_out[0], 4'b0000);
    step(1);
    check("t5.out_edge18", d_out[0], 4'b1100);
    step(5);

    // one-cycle debounce build follows the input three edges later
    in_a = 4'b0101;
    step(2);
    check("t6.d1_edge2", d_out[2], 4'b1100);
    step(1);
    check("t6.d1_edge3", d_out[2], 4'b0101);
    step(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
